// File: rtl/cp0_if.sv
// Bus between the MIPS pipeline and the coprocessor-0 register file.
//   slave  : the register file (cp0_reg) - takes mtc0/mfc0/exception inputs,
//            drives register values, mfc0 read data and the timer request.
//   master : the pipeline side (WB, MEM and the pipeline controller).
// Signals:
//   we_i/waddr_i/data_i        mtc0 write from WB
//   raddr_i -> data_o          combinational mfc0 read
//   int_i                      external interrupt lines (Cause IP7..IP2)
//   excepttype_i, current_inst_addr_i, is_in_delayslot_i  exception event from MEM
//   *_o                        architectural register values, cp0_epc_o, timer_int_o
interface cp0_if;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] data_i;
    logic [4:0]  raddr_i;
    logic [5:0]  int_i;
    logic [31:0] excepttype_i;
    logic [31:0] current_inst_addr_i;
    logic        is_in_delayslot_i;
    logic [31:0] data_o;
    logic [31:0] count_o;
    logic [31:0] compare_o;
    logic [31:0] status_o;
    logic [31:0] cause_o;
    logic [31:0] epc_o;
    logic [31:0] config_o;
    logic [31:0] prid_o;
    logic [31:0] cp0_epc_o;
    logic        timer_int_o;

    modport slave (
        input  we_i, waddr_i, data_i, raddr_i, int_i,
               excepttype_i, current_inst_addr_i, is_in_delayslot_i,
        output data_o, count_o, compare_o, status_o, cause_o, epc_o,
               config_o, prid_o, cp0_epc_o, timer_int_o
    );

    modport master (
        output we_i, waddr_i, data_i, raddr_i, int_i,
               excepttype_i, current_inst_addr_i, is_in_delayslot_i,
        input  data_o, count_o, compare_o, status_o, cause_o, epc_o,
               config_o, prid_o, cp0_epc_o, timer_int_o
    );
endinterface

// File: rtl/cp0_reg.sv
// Coprocessor-0 register file for the 5-stage MIPS pipeline (MEM/WB boundary).
// Holds Count, Compare, Status, Cause, EPC, Config and PRId; applies mtc0
// writes from WB and exception/eret events from MEM; raises the Count/Compare
// timer interrupt.
// Ports:
//   clk  - clock; all register updates on its rising edge
//   rst  - asynchronous, active-high reset
//   bus  - cp0_if.slave: mtc0 write, mfc0 read, interrupts, exception event,
//          register value outputs, cp0_epc_o and timer_int_o
module cp0_reg #(
    parameter logic [31:0] PRID         = 32'h004C0102,
    parameter logic [31:0] CONFIG_RESET = 32'h00008000,
    parameter logic [31:0] STATUS_RESET = 32'h10000000
) (
    input  logic  clk,
    input  logic  rst,
    cp0_if.slave  bus
);
    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_STATUS  = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;
    localparam logic [4:0] REG_PRID    = 5'd15;
    localparam logic [4:0] REG_CONFIG  = 5'd16;

    // Cause bits software may change: IV, WP, IP1, IP0.
    localparam logic [31:0] CAUSE_WMASK = 32'h00C00300;

    logic [31:0] count_q, compare_q, status_q, cause_q, epc_q;
    logic        timer_q;
    logic [31:0] status_nxt, cause_nxt, epc_nxt;
    logic [31:0] rdata;
    logic        wr_count, wr_compare, wr_status, wr_cause, wr_epc;
    logic        exc_valid, exc_eret;
    logic [4:0]  exc_code;

    assign wr_count   = bus.we_i && (bus.waddr_i == REG_COUNT);
    assign wr_compare = bus.we_i && (bus.waddr_i == REG_COMPARE);
    assign wr_status  = bus.we_i && (bus.waddr_i == REG_STATUS);
    assign wr_cause   = bus.we_i && (bus.waddr_i == REG_CAUSE);
    assign wr_epc     = bus.we_i && (bus.waddr_i == REG_EPC);
    assign exc_eret   = (bus.excepttype_i == 32'he);

    // Only the recognised exception codes touch state; anything else is ignored.
    always_comb begin
        exc_valid = 1'b1;
        exc_code  = 5'h00;
        case (bus.excepttype_i)
            32'h1:   exc_code = 5'h00;
            32'h8:   exc_code = 5'h08;
            32'ha:   exc_code = 5'h0a;
            32'hd:   exc_code = 5'h0d;
            32'hc:   exc_code = 5'h0c;
            default: exc_valid = 1'b0;
        endcase
    end

    // mtc0 is applied first, then the exception/eret fields override it.
    // Nesting is decided from the EXL bit held before this edge.
    always_comb begin
        status_nxt = wr_status ? bus.data_i : status_q;
        epc_nxt    = wr_epc ? bus.data_i : epc_q;
        cause_nxt  = cause_q;
        if (wr_cause) begin
            cause_nxt = (cause_q & ~CAUSE_WMASK) | (bus.data_i & CAUSE_WMASK);
        end
        cause_nxt[15:10] = bus.int_i;

        if (exc_valid) begin
            status_nxt[1]   = 1'b1;
            cause_nxt[6:2]  = exc_code;
            if (!status_q[1]) begin
                if (bus.is_in_delayslot_i) begin
                    epc_nxt       = bus.current_inst_addr_i - 32'd4;
                    cause_nxt[31] = 1'b1;
                end else begin
                    epc_nxt       = bus.current_inst_addr_i;
                    cause_nxt[31] = 1'b0;
                end
            end
        end else if (exc_eret) begin
            status_nxt[1] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= 32'h0;
            compare_q <= 32'h0;
            status_q  <= STATUS_RESET;
            cause_q   <= 32'h0;
            epc_q     <= 32'h0;
            timer_q   <= 1'b0;
        end else begin
            count_q <= wr_count ? bus.data_i : count_q + 32'd1;
            // A Compare write clears the request even if the match fires this edge.
            if (wr_compare) begin
                compare_q <= bus.data_i;
                timer_q   <= 1'b0;
            end else if ((compare_q != 32'h0) && (count_q == compare_q)) begin
                timer_q <= 1'b1;
            end
            status_q <= status_nxt;
            cause_q  <= cause_nxt;
            epc_q    <= epc_nxt;
        end
    end

    // mfc0 read path: current state only, no bypass of the WB write.
    always_comb begin
        rdata = 32'h0;
        case (bus.raddr_i)
            REG_COUNT:   rdata = count_q;
            REG_COMPARE: rdata = compare_q;
            REG_STATUS:  rdata = status_q;
            REG_CAUSE:   rdata = cause_q;
            REG_EPC:     rdata = epc_q;
            REG_PRID:    rdata = PRID;
            REG_CONFIG:  rdata = CONFIG_RESET;
            default:     rdata = 32'h0;
        endcase
    end

    assign bus.data_o      = rdata;
    assign bus.count_o     = count_q;
    assign bus.compare_o   = compare_q;
    assign bus.status_o    = status_q;
    assign bus.cause_o     = cause_q;
    assign bus.epc_o       = epc_q;
    assign bus.config_o    = CONFIG_RESET;
    assign bus.prid_o      = PRID;
    assign bus.cp0_epc_o   = epc_q;
    assign bus.timer_int_o = timer_q;
endmodule

// File: tb/tb_cp0_reg.sv
module tb_cp0_reg;
    logic clk;
    logic rst;
    cp0_if bus ();

    cp0_reg dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference state
    logic [31:0] m_count, m_compare, m_status, m_cause, m_epc;
    logic        m_timer;
    int unsigned exc_tbl [logic [31:0]];

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] data;
        logic [31:0] exc;
        logic [31:0] addr;
        logic        ds;
        logic [31:0] exp_status;
        logic [31:0] exp_cause;
        logic [31:0] exp_epc;
    } vec_t;
    vec_t tbl [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a);
        case (a)
            5'd9:    return m_count;
            5'd11:   return m_compare;
            5'd12:   return m_status;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return 32'h004C0102;
            5'd16:   return 32'h00008000;
            default: return 32'h0;
        endcase
    endfunction

    function automatic void model_reset();
        m_count   = 32'h0;
        m_compare = 32'h0;
        m_status  = 32'h10000000;
        m_cause   = 32'h0;
        m_epc     = 32'h0;
        m_timer   = 1'b0;
    endfunction

    // One clock edge of architectural behaviour.
    function automatic void model_step();
        logic        old_exl = m_status[1];
        logic        fire    = (m_compare != 32'h0) && (m_count == m_compare);
        logic [4:0]  a       = bus.waddr_i;
        logic [31:0] d       = bus.data_i;
        logic        w       = bus.we_i;
        logic [31:0] t       = bus.excepttype_i;

        if (w && a == 5'd9) m_count = d;
        else                m_count = m_count + 32'd1;

        if (w && a == 5'd11) begin
            m_compare = d;
            m_timer   = 1'b0;
        end else if (fire) begin
            m_timer = 1'b1;
        end

        if (w && a == 5'd12) m_status = d;
        if (w && a == 5'd14) m_epc = d;
        if (w && a == 5'd13) begin
            foreach (d[b]) if (b == 8 || b == 9 || b == 22 || b == 23) m_cause[b] = d[b];
        end
        m_cause[15:10] = bus.int_i;

        if (exc_tbl.exists(t)) begin
            m_status[1]   = 1'b1;
            m_cause[6:2]  = exc_tbl[t][4:0];
            if (!old_exl) begin
                m_epc         = bus.is_in_delayslot_i ? bus.current_inst_addr_i - 32'd4
                                                      : bus.current_inst_addr_i;
                m_cause[31]   = bus.is_in_delayslot_i;
            end
        end else if (t == 32'he) begin
            m_status[1] = 1'b0;
        end
    endfunction

    task automatic compare_all(input string tag);
        check({tag, ".count"},   bus.count_o,   m_count);
        check({tag, ".compare"}, bus.compare_o, m_compare);
        check({tag, ".status"},  bus.status_o,  m_status);
        check({tag, ".cause"},   bus.cause_o,   m_cause);
        check({tag, ".epc"},     bus.epc_o,     m_epc);
        check({tag, ".cp0_epc"}, bus.cp0_epc_o, m_epc);
        check({tag, ".config"},  bus.config_o,  32'h00008000);
        check({tag, ".prid"},    bus.prid_o,    32'h004C0102);
        check({tag, ".timer"},   {31'h0, bus.timer_int_o}, {31'h0, m_timer});
        check({tag, ".data_o"},  bus.data_o,    model_read(bus.raddr_i));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all(tag);
    endtask

    task automatic set_idle();
        bus.we_i                = 1'b0;
        bus.waddr_i             = 5'd0;
        bus.data_i              = 32'h0;
        bus.raddr_i             = 5'd0;
        bus.int_i               = 6'h0;
        bus.excepttype_i        = 32'h0;
        bus.current_inst_addr_i = 32'h0;
        bus.is_in_delayslot_i   = 1'b0;
    endtask

    // Assert reset away from the clock edge, check it acts immediately, hold it
    // across one edge with whatever inputs are present, release at a negedge.
    task automatic apply_reset(input string tag);
        rst = 1'b1;
        #1;
        model_reset();
        compare_all({tag, ".async"});
        check({tag, ".status_rv"}, bus.status_o, 32'h10000000);
        check({tag, ".count_rv"},  bus.count_o,  32'h0);
        check({tag, ".epc_rv"},    bus.epc_o,    32'h0);
        @(posedge clk);
        @(negedge clk);
        compare_all({tag, ".held"});
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        exc_tbl[32'h1] = 0;
        exc_tbl[32'h8] = 8;
        exc_tbl[32'ha] = 10;
        exc_tbl[32'hd] = 13;
        exc_tbl[32'hc] = 12;

        //          we    waddr  data           exc     addr          ds    status        cause         epc
        tbl[0]  = '{1'b0, 5'd0,  32'h0,         32'h8, 32'h1000, 1'b1, 32'h10000002, 32'h80000020, 32'h00000FFC};
        tbl[1]  = '{1'b0, 5'd0,  32'h0,         32'he, 32'h0,    1'b0, 32'h10000000, 32'h80000020, 32'h00000FFC};
        tbl[2]  = '{1'b0, 5'd0,  32'h0,         32'h8, 32'h1800, 1'b0, 32'h10000002, 32'h00000020, 32'h00001800};
        tbl[3]  = '{1'b0, 5'd0,  32'h0,         32'hc, 32'h2000, 1'b1, 32'h10000002, 32'h00000030, 32'h00001800};
        tbl[4]  = '{1'b0, 5'd0,  32'h0,         32'he, 32'h0,    1'b0, 32'h10000000, 32'h00000030, 32'h00001800};
        tbl[5]  = '{1'b1, 5'd14, 32'h0000DEAD,  32'ha, 32'h3000, 1'b0, 32'h10000002, 32'h00000028, 32'h00003000};
        tbl[6]  = '{1'b0, 5'd0,  32'h0,         32'he, 32'h0,    1'b0, 32'h10000000, 32'h00000028, 32'h00003000};
        tbl[7]  = '{1'b0, 5'd0,  32'h0,         32'h5, 32'h7000, 1'b1, 32'h10000000, 32'h00000028, 32'h00003000};
        tbl[8]  = '{1'b1, 5'd13, 32'hFFFFFFFF,  32'h0, 32'h0,    1'b0, 32'h10000000, 32'h00C00328, 32'h00003000};
        tbl[9]  = '{1'b0, 5'd0,  32'h0,         32'h1, 32'h4000, 1'b1, 32'h10000002, 32'h80C00300, 32'h00003FFC};
        tbl[10] = '{1'b1, 5'd12, 32'h0000FF01,  32'h0, 32'h0,    1'b0, 32'h0000FF01, 32'h80C00300, 32'h00003FFC};
        tbl[11] = '{1'b1, 5'd12, 32'h0,         32'hd, 32'h5000, 1'b0, 32'h00000002, 32'h00C00334, 32'h00005000};
        tbl[12] = '{1'b1, 5'd12, 32'h00000012,  32'he, 32'h0,    1'b0, 32'h00000010, 32'h00C00334, 32'h00005000};

        set_idle();
        rst = 1'b1;
        @(negedge clk);
        apply_reset("por");

        // Count runs from 0 after reset
        for (int i = 0; i < 4; i++) begin
            tick("cnt");
            check("count_seq", bus.count_o, 32'(i + 1));
        end

        // Timer: Compare=5 written at Count=0
        apply_reset("tmr_rst");
        bus.we_i = 1'b1; bus.waddr_i = 5'd11; bus.data_i = 32'd5;
        tick("tmr_wr");
        set_idle();
        for (int i = 0; i < 4; i++) begin
            tick("tmr_wait");
            check("timer_before", {31'h0, bus.timer_int_o}, 32'd0);
        end
        for (int i = 0; i < 3; i++) begin
            tick("tmr_fire");
            check("timer_sticky", {31'h0, bus.timer_int_o}, 32'd1);
        end
        bus.we_i = 1'b1; bus.waddr_i = 5'd11; bus.data_i = 32'h100;
        tick("tmr_clr");
        check("timer_clear", {31'h0, bus.timer_int_o}, 32'd0);
        set_idle();

        // Match and Compare write on the same edge: write wins
        apply_reset("mw_rst");
        bus.we_i = 1'b1; bus.waddr_i = 5'd11; bus.data_i = 32'd3;
        tick("mw_wr3");
        set_idle();
        tick("mw_c1");
        tick("mw_c2");
        bus.we_i = 1'b1; bus.waddr_i = 5'd11; bus.data_i = 32'd7;
        tick("mw_wr7");
        check("timer_write_wins", {31'h0, bus.timer_int_o}, 32'd0);
        set_idle();
        for (int i = 0; i < 3; i++) tick("mw_wait");
        check("timer_after_wait", {31'h0, bus.timer_int_o}, 32'd0);
        tick("mw_fire");
        check("timer_fire7", {31'h0, bus.timer_int_o}, 32'd1);

        // Exception / eret / mtc0 vector table
        apply_reset("tbl_rst");
        foreach (tbl[i]) begin
            bus.we_i                = tbl[i].we;
            bus.waddr_i             = tbl[i].waddr;
            bus.data_i              = tbl[i].data;
            bus.excepttype_i        = tbl[i].exc;
            bus.current_inst_addr_i = tbl[i].addr;
            bus.is_in_delayslot_i   = tbl[i].ds;
            bus.raddr_i             = 5'd13;
            tick($sformatf("tbl%0d", i));
            check($sformatf("tbl%0d.status", i), bus.status_o, tbl[i].exp_status);
            check($sformatf("tbl%0d.cause", i),  bus.cause_o,  tbl[i].exp_cause);
            check($sformatf("tbl%0d.epc", i),    bus.epc_o,    tbl[i].exp_epc);
            set_idle();
        end

        // Cause write with interrupts pending
        apply_reset("cause_rst");
        bus.int_i = 6'b101010;
        bus.we_i = 1'b1; bus.waddr_i = 5'd13; bus.data_i = 32'hFFFFFFFF;
        bus.raddr_i = 5'd13;
        tick("cause_wr");
        check("cause_mfc0", bus.data_o, 32'h00C0AB00);

        // Count wrap through an mtc0
        set_idle();
        bus.we_i = 1'b1; bus.waddr_i = 5'd9; bus.data_i = 32'hFFFFFFFF;
        tick("cnt_wr");
        check("count_loaded", bus.count_o, 32'hFFFFFFFF);
        set_idle();
        tick("cnt_wrap");
        check("count_wrap", bus.count_o, 32'h0);

        // Reset asserted mid-exception, with an exception held on the inputs
        bus.excepttype_i = 32'h8; bus.current_inst_addr_i = 32'h1234; bus.is_in_delayslot_i = 1'b1;
        tick("pre_rst");
        apply_reset("mid_rst");
        set_idle();

        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            logic [31:0] pool [12];
            pool = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h1, 32'h8, 32'ha, 32'hc, 32'hd, 32'he, 32'he, 32'h5};
            bus.we_i = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 7))
                0: bus.waddr_i = 5'd9;
                1: bus.waddr_i = 5'd11;
                2: bus.waddr_i = 5'd12;
                3: bus.waddr_i = 5'd13;
                4: bus.waddr_i = 5'd14;
                5: bus.waddr_i = 5'd15;
                6: bus.waddr_i = 5'd16;
                default: bus.waddr_i = 5'($urandom_range(0, 31));
            endcase
            bus.data_i = $urandom;
            if (bus.waddr_i == 5'd11 && $urandom_range(0, 1) == 1)
                bus.data_i = m_count + 32'($urandom_range(0, 6));
            bus.raddr_i             = 5'($urandom_range(0, 31));
            bus.int_i               = 6'($urandom);
            bus.excepttype_i        = (i % 37 == 5) ? $urandom : pool[$urandom_range(0, 11)];
            bus.current_inst_addr_i = $urandom;
            bus.is_in_delayslot_i   = 1'($urandom);
            tick($sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
